// File: rtl/pattern_scan.sv
// Memory-reading pattern counter: scans NUM_BYTES bytes from BASE_ADDR and counts
// in-byte, per-byte-hit and whole-stream occurrences of pat. Optional PATTERN_SCAN_MASK_EN adds pat_mask.
module pattern_scan #(
    parameter int PAT_W     = 5,
    parameter int NUM_BYTES = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PAT_W-1:0]  pat,
`ifdef PATTERN_SCAN_MASK_EN
    input  logic [PAT_W-1:0]  pat_mask,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt_byte,
    output logic [CNT_W-1:0]  cnt_hit,
    output logic [CNT_W-1:0]  cnt_stream
);

    localparam int unsigned WIN_W   = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam int unsigned LAST_IN = 8 - PAT_W;
    localparam int unsigned SW      = ((CNT_W > 4) ? CNT_W : 4) + 1;
    localparam logic [SW-1:0]     CNT_MAX = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};
    localparam logic [ADDR_W:0]   LAST    = (ADDR_W + 1)'(NUM_BYTES);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [ADDR_W:0]    idx;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   mask_q;
    logic [WIN_W-1:0]   win_q;
    logic               valid;
    logic               first;

    logic [WIN_W+7:0]   ext;
    logic [3:0]         inc_byte;
    logic [3:0]         inc_cross;
    logic [3:0]         inc_stream;

`ifndef PATTERN_SCAN_MASK_EN
    assign mask_q = '1;
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > CNT_MAX)
            return '1;
        return s[CNT_W-1:0];
    endfunction

    // Windows ending at bit j of the incoming byte; those reaching above bit 7 cross into history.
    always_comb begin
        ext       = {win_q, mem_rd_data};
        inc_byte  = '0;
        inc_cross = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (((ext[j +: PAT_W] ^ pat_q) & mask_q) == '0) begin
                if (j <= LAST_IN)
                    inc_byte = inc_byte + 4'd1;
                else
                    inc_cross = inc_cross + 4'd1;
            end
        end
        inc_stream = first ? inc_byte : inc_byte + inc_cross;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pat_q      <= '0;
`ifdef PATTERN_SCAN_MASK_EN
            mask_q     <= '0;
`endif
            win_q      <= '0;
            valid      <= 1'b0;
            first      <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_byte   <= '0;
            cnt_hit    <= '0;
            cnt_stream <= '0;
        end else begin
            done  <= 1'b0;
            valid <= mem_rd;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q      <= pat;
`ifdef PATTERN_SCAN_MASK_EN
                        mask_q     <= pat_mask;
`endif
                        cnt_byte   <= '0;
                        cnt_hit    <= '0;
                        cnt_stream <= '0;
                        idx        <= (ADDR_W + 1)'(1);
                        mem_addr   <= BASE;
                        mem_rd     <= 1'b1;
                        busy       <= 1'b1;
                        first      <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (idx == LAST) begin
                        mem_rd <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        mem_addr <= BASE + idx[ADDR_W-1:0];
                        idx      <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Read data lags the address by one cycle, so processing follows the registered read strobe.
            if (valid) begin
                cnt_byte   <= sat_add(cnt_byte, inc_byte);
                cnt_hit    <= sat_add(cnt_hit, {3'b000, (inc_byte != 4'd0)});
                cnt_stream <= sat_add(cnt_stream, inc_stream);
                win_q      <= mem_rd_data[WIN_W-1:0];
                first      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_scan.sv
// Self-checking bench for pattern_scan: two instances (default, and CNT_W=6 with a wrapping base)
// checked against a bit-stream reference model.
module tb_pattern_scan;

    localparam int PW    = 5;
    localparam int NB    = 32;
    localparam int AW    = 8;
    localparam int CW0   = 8;
    localparam int CW1   = 6;
    localparam int BASE1 = 240;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [PW-1:0]  pat = '0;
    logic [PW-1:0]  pat_mask = '1;
    logic [7:0]     mem [256];

    logic [AW-1:0]  addr0, addr1;
    logic           rd0, rd1, busy0, busy1, done0, done1;
    logic [7:0]     rdd0, rdd1;
    logic [CW0-1:0] cb0, ch0, cs0;
    logic [CW1-1:0] cb1, ch1, cs1;

    int n_total = 0;
    int n_bad   = 0;
    int rd_cnt, addr_err, done_cnt0, done_cnt1;

    pattern_scan #(.PAT_W(PW), .NUM_BYTES(NB), .ADDR_W(AW), .BASE_ADDR(0), .CNT_W(CW0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pat(pat),
`ifdef PATTERN_SCAN_MASK_EN
        .pat_mask(pat_mask),
`endif
        .mem_addr(addr0), .mem_rd(rd0), .mem_rd_data(rdd0), .busy(busy0), .done(done0),
        .cnt_byte(cb0), .cnt_hit(ch0), .cnt_stream(cs0)
    );

    pattern_scan #(.PAT_W(PW), .NUM_BYTES(NB), .ADDR_W(AW), .BASE_ADDR(BASE1), .CNT_W(CW1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pat(pat),
`ifdef PATTERN_SCAN_MASK_EN
        .pat_mask(pat_mask),
`endif
        .mem_addr(addr1), .mem_rd(rd1), .mem_rd_data(rdd1), .busy(busy1), .done(done1),
        .cnt_byte(cb1), .cnt_hit(ch1), .cnt_stream(cs1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdd0 <= mem[addr0];
        rdd1 <= mem[addr1];
    end

    always @(negedge clk) begin
        if (rd0) begin
            if (int'(addr0) != (rd_cnt % 256)) addr_err++;
            rd_cnt++;
        end
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: flatten the scanned bytes into one MSB-first bit stream and slide the pattern over it.
    task automatic model(input int base, input int cw, input logic [PW-1:0] p,
                         output int eb, output int eh, output int es);
        bit         s[$];
        bit         hit[NB];
        bit         m;
        logic [7:0] v;
        int         sat;
        eb = 0; eh = 0; es = 0;
        for (int b = 0; b < NB; b++) begin
            v = mem[(base + b) % 256];
            for (int i = 7; i >= 0; i--) s.push_back(v[i]);
        end
        for (int q = 0; q <= 8 * NB - PW; q++) begin
            m = 1'b1;
            for (int i = 0; i < PW; i++)
                if (pat_mask[PW-1-i] && (s[q+i] != p[PW-1-i])) m = 1'b0;
            if (m) begin
                es++;
                if ((q / 8) == ((q + PW - 1) / 8)) begin
                    eb++;
                    hit[q/8] = 1'b1;
                end
            end
        end
        foreach (hit[i]) if (hit[i]) eh++;
        sat = (1 << cw) - 1;
        if (eb > sat) eb = sat;
        if (eh > sat) eh = sat;
        if (es > sat) es = sat;
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < 256; i++) begin
            case (kind)
                0: mem[i] = 8'h00;
                1: mem[i] = 8'hAA;
                default: mem[i] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 8'h55);
            endcase
        end
    endtask

    task automatic do_scan(input string name, input logic [PW-1:0] p, input bit disturb,
                           input bit use_lit, input int lb, input int lh, input int ls);
        int eb0, eh0, es0, eb1, eh1, es1, cyc;
        model(0, CW0, p, eb0, eh0, es0);
        model(BASE1, CW1, p, eb1, eh1, es1);
        if (use_lit) begin
            eb0 = lb; eh0 = lh; es0 = ls;
        end
        @(negedge clk);
        rd_cnt = 0; addr_err = 0; done_cnt0 = 0; done_cnt1 = 0;
        pat = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({name, " busy"}, busy0, 1);
        while (!done0 && cyc < NB + 12) begin
            if (disturb && (cyc == 3 || cyc == 9 || cyc == 20)) begin
                start = 1'b1;
                pat = PW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, " done cycle"}, cyc, NB + 2);
        check({name, " busy at done"}, busy0, 0);
        check({name, " dut1 done"}, done1, 1);
        check({name, " cnt_byte"}, cb0, eb0);
        check({name, " cnt_hit"}, ch0, eh0);
        check({name, " cnt_stream"}, cs0, es0);
        check({name, " w6 cnt_byte"}, cb1, eb1);
        check({name, " w6 cnt_hit"}, ch1, eh1);
        check({name, " w6 cnt_stream"}, cs1, es1);
        @(negedge clk);
        check({name, " done pulse width"}, done0, 0);
        repeat (3) @(negedge clk);
        check({name, " done count"}, done_cnt0, 1);
        check({name, " w6 done count"}, done_cnt1, 1);
        check({name, " rd cycles"}, rd_cnt, NB);
        check({name, " addr errors"}, addr_err, 0);
        check({name, " hold cnt_stream"}, cs0, es0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill(0);
        rd_cnt = 0; addr_err = 0; done_cnt0 = 0; done_cnt1 = 0;
        repeat (2) @(negedge clk);
        check("reset ctl", {busy0, done0, rd0, addr0}, 0);
        check("reset cnt", {cb0, ch0, cs0}, 0);
        check("reset w6", {busy1, done1, rd1, addr1, cb1, ch1, cs1}, 0);
        reset = 1'b0;

        fill(1);
        do_scan("aa", 5'b10101, 1'b0, 1'b1, 64, 32, 126);
        fill(0);
        do_scan("zeros", 5'b00000, 1'b0, 1'b1, 128, 32, 252);
        mem[0] = 8'h07; mem[1] = 8'hC0;
        mem[BASE1] = 8'h07; mem[BASE1 + 1] = 8'hC0;
        do_scan("crossing", 5'b11111, 1'b0, 1'b1, 0, 0, 1);
        fill(0);
        do_scan("no match", 5'b11111, 1'b0, 1'b1, 0, 0, 0);

        // Reset during a scan: asynchronous clear, no done pulse, clean restart.
        @(negedge clk);
        done_cnt0 = 0; done_cnt1 = 0;
        pat = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid scan busy", busy0, 1);
        #2 reset = 1'b1;
        #1;
        check("async rst ctl", {busy0, done0, rd0, addr0}, 0);
        check("async rst cnt", {cb0, ch0, cs0}, 0);
        check("async rst w6", {busy1, done1, rd1, addr1, cb1, ch1, cs1}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (NB + 4) @(negedge clk);
        check("no done after rst", done_cnt0 + done_cnt1, 0);
        do_scan("after rst", 5'b00000, 1'b0, 1'b1, 128, 32, 252);

        fill(2);
        do_scan("disturbed", PW'($urandom), 1'b1, 1'b0, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            fill(2);
            do_scan($sformatf("rand%0d", t), PW'($urandom), 1'b0, 1'b0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
